stream_fifo: RTL and testbench
==============================

Name: stream_fifo

Overview:
- Circular FIFO with valid/ready handshakes on both sides.
- Sits directly upstream of the length/occupancy checker.
- Exports one-cycle push and pop strobes that drive the checker's up_enable and down_enable inputs.
- Also tracks its own level, so full/empty are produced locally with no dependency on the checker.

Parameters:
- DATA_W, 8, width of each stored word.
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of FIFO contents.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  DATA_W  word to store.
- in_ready  output  1  FIFO can accept a word this cycle.
- out_valid  output  1  out_data holds the oldest stored word.
- out_data  output  DATA_W  head-of-FIFO word.
- out_ready  input  1  consumer takes out_data this cycle.
- push  output  1  write accepted this cycle; feeds checker up_enable.
- pop  output  1  read accepted this cycle; feeds checker down_enable.
- level  output  ADDR_W+1  number of stored words, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.

Behaviour:
- Reset (rst low, asynchronous): wr_ptr=0, rd_ptr=0, level=0.
  - Resulting outputs: empty=1, full=0, out_valid=0, push=0, pop=0, in_ready=1 once rst is released.
  - Storage array is not reset. out_data is don't-care while empty.
- Handshake signals (combinational):
  - in_ready = !full && !flush.
  - out_valid = !empty && !flush.
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
- Write: on push, mem[wr_ptr] <= in_data and wr_ptr <= wr_ptr+1 (mod DEPTH).
- Read: out_data = mem[rd_ptr], combinational (first-word fall-through). On pop, rd_ptr <= rd_ptr+1 (mod DEPTH).
- Latency: a word pushed in cycle N appears with out_valid=1 in cycle N+1. There is no same-cycle bypass when empty.
- Level update:
  - push only: level+1.
  - pop only: level-1.
  - push and pop together: level unchanged, both pointers advance.
  - neither: hold.
- Full: in_ready=0, so push cannot occur even if out_ready=1 in the same cycle. A simultaneous pop still drains one entry.
- Empty: out_valid=0, so pop cannot occur and level never underflows.
- Wrap-around: pointers roll over from DEPTH-1 to 0 with no gap. Full and empty are decided from level only, never from pointer equality.
- Flush:
  - Takes priority over everything.
  - Forces in_ready=0 and out_valid=0, hence push=pop=0 that cycle.
  - Next edge sets wr_ptr=rd_ptr=level=0.
  - The checker is cleared by its own reset; flush produces no strobes.
- Reset mid-transfer: words in flight are lost. The first cycle after release behaves exactly as after a power-on reset.
- Invariant: level equals the running sum of push minus pop since the last reset/flush.
  - The checker's count must therefore match level (mod its width) whenever both share reset.

Decomposition:
- Package stream_fifo_pkg:
  - DATA_W_DEF=8 and DEPTH_DEF=8.
  - Function to compute ADDR_W.
  - typedef data_t (logic [DATA_W_DEF-1:0]).
- One sub-module, fifo_mem:
  - DEPTH x DATA_W storage.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
  - No reset.
- Pointers, level and handshake logic stay in stream_fifo.

Test Plan:
- Reset then idle: rst low 2 cycles, release -> level=0, empty=1, full=0, in_ready=1, out_valid=0, push=pop=0.
- Fill to full: DEPTH=8, push 0x10..0x17 with out_ready=0 -> after 8th push level=8, full=1, in_ready=0; extra in_valid gives push=0.
- Drain in order: from full, out_ready=1 for 8 cycles -> out_data 0x10..0x17 in order, pop=1 each cycle, then empty=1 and out_valid=0.
- Simultaneous push/pop with wrap: hold level=3, stream 20 words with in_valid=out_ready=1 -> level stays 3, push=pop=1 every cycle, data order preserved across pointer wrap.
- Flush and reset mid-operation:
  - Flush at level=5 -> push=pop=0 that cycle; next cycle level=0, empty=1.
  - Assert rst at level=4 -> outputs return to reset values immediately, without waiting for a clock edge.
- Checker cross-check: connect push/pop to a 4-bit up/down counter under random valid/ready for 1000 cycles -> counter equals level every cycle.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
// Shared defaults, types and helpers for the stream_fifo slice.
package stream_fifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 8;

  typedef logic [DATA_W_DEF-1:0] data_t;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register file: synchronous write, asynchronous read, no reset.
module fifo_mem
  import stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = addr_w(DEPTH_DEF)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Circular first-word-fall-through FIFO with valid/ready on both sides and
// one-cycle push/pop strobes for a downstream occupancy checker.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              push,
  output logic              pop,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] LEVEL_MAX = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // Full/empty come from the level alone; pointer equality is ambiguous.
  always_comb begin
    full      = (level == LEVEL_MAX);
    empty     = (level == '0);
    in_ready  = !full && !flush;
    out_valid = !empty && !flush;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(out_data)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Randomized self-checking bench for stream_fifo against a queue-based model.
module tb_stream_fifo;
  import stream_fifo_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  data_t       in_data;
  logic        in_ready;
  logic        out_valid;
  data_t       out_data;
  logic        out_ready;
  logic        push;
  logic        pop;
  logic [3:0]  level;
  logic        full;
  logic        empty;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  data_t       q[$];
  logic [3:0]  cnt;
  bit          cnt_on = 1'b0;

  always #5 clk = ~clk;

  stream_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .push     (push),
    .pop      (pop),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"},     32'(level),     32'd0);
    check({tag, "_empty"},     32'(empty),     32'd1);
    check({tag, "_full"},      32'(full),      32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_push"},      32'(push),      32'd0);
    check({tag, "_pop"},       32'(pop),       32'd0);
  endtask

  // One clock: drive inputs after the falling edge, check against the model,
  // then advance the model on the rising edge.
  task automatic cycle(input logic v, input data_t d, input logic r, input logic f);
    bit   full_e, empty_e, ir_e, ov_e, push_e, pop_e;
    logic act_push, act_pop;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    #1;
    full_e  = (q.size() == DEPTH);
    empty_e = (q.size() == 0);
    ir_e    = !full_e && !f;
    ov_e    = !empty_e && !f;
    push_e  = v && ir_e;
    pop_e   = r && ov_e;
    check("level",     32'(level),     32'(q.size()));
    check("full",      32'(full),      32'(full_e));
    check("empty",     32'(empty),     32'(empty_e));
    check("in_ready",  32'(in_ready),  32'(ir_e));
    check("out_valid", 32'(out_valid), 32'(ov_e));
    check("push",      32'(push),      32'(push_e));
    check("pop",       32'(pop),       32'(pop_e));
    if (ov_e) check("out_data", 32'(out_data), 32'(q[0]));
    if (cnt_on) check("checker_cnt", 32'(cnt), 32'(level));
    act_push = push;
    act_pop  = pop;
    @(posedge clk);
    if (cnt_on) cnt = cnt + 4'(act_push) - 4'(act_pop);
    if (f) q.delete();
    else begin
      if (pop_e)  void'(q.pop_front());
      if (push_e) q.push_back(d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    q.delete();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_state("rst_held");
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full, then an extra push attempt is refused.
    for (int i = 0; i < 8; i++) cycle(1'b1, data_t'(8'h10 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    // Drain in order.
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Full with both sides active: only the pop goes through.
    for (int i = 0; i < 8; i++) cycle(1'b1, data_t'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'hAB, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming at level 3 across pointer wrap.
    for (int i = 0; i < 3; i++) cycle(1'b1, data_t'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, data_t'($urandom), 1'b1, 1'b0);
    check("stream_level", 32'(q.size()), 32'd3);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Flush at level 5 with valid/ready both high.
    for (int i = 0; i < 2; i++) cycle(1'b1, data_t'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset at level 4 takes effect without a clock edge.
    for (int i = 0; i < 4; i++) cycle(1'b1, data_t'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("pre_rst_level", 32'(level), 32'd4);
    rst = 1'b0;
    #1;
    check_reset_state("async_rst");
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic with an up/down checker counter on push/pop.
    do_reset();
    cnt = '0;
    cnt_on = 1'b1;
    for (int i = 0; i < 1000; i++)
      cycle(1'($urandom_range(0, 1)), data_t'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    cnt_on = 1'b0;

    // Random traffic including occasional flushes.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), data_t'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
